// File: rtl/comm_pkg.sv
// Shared link-quality constants and helpers: frame width and a population count
// used by the BER monitor and later BER/SNR blocks.
package comm_pkg;

  localparam int FRAME_W = 16;
  localparam int POP_W   = $clog2(FRAME_W) + 1;

  function automatic logic [POP_W-1:0] popcount(input logic [FRAME_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < FRAME_W; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ber_ref_fifo.sv
// Reference-word FIFO for the BER monitor: synchronous write/read, show-ahead head,
// explicit level counter so full/empty never depend on pointer wrap.
module ber_ref_fifo #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/ber_monitor.sv
// End-of-chain link checker: compares each decoded word with its buffered reference
// and keeps saturating error statistics. Burst tracking built with BER_MONITOR_BURST_EN.
module ber_monitor
  import comm_pkg::*;
#(
  parameter  int DATA_W = FRAME_W,
  parameter  int DEPTH  = 4,
  parameter  int CNT_W  = 32,
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              clear,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  bit_err_cnt,
  output logic [CNT_W-1:0]  frame_err_cnt,
  output logic [DATA_W-1:0] last_err_mask,
  output logic              overflow,
  output logic              orphan,
`ifdef BER_MONITOR_BURST_EN
  output logic [CNT_W-1:0]  burst_cur,
  output logic [CNT_W-1:0]  burst_max,
`endif
  output logic [LVL_W-1:0]  fifo_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (DATA_W != FRAME_W) begin : g_width_check
    $error("ber_monitor: DATA_W must equal comm_pkg::FRAME_W");
  end

  logic              push, pop, full, empty;
  logic [DATA_W-1:0] head, m;
  logic [POP_W-1:0]  m_ones;
  logic [CNT_W:0]    bit_sum;

  ber_ref_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ref_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (tx_data),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign tx_ready = ~full;
  assign push     = tx_valid & ~full;
  // Pop decision uses the pre-push level, so a push into an empty FIFO never satisfies the same rx.
  assign pop      = rx_valid & ~empty;
  assign m        = head ^ rx_data;
  assign m_ones   = popcount(m);
  assign bit_sum  = {1'b0, bit_err_cnt} + (CNT_W+1)'(m_ones);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      frame_cnt     <= '0;
      bit_err_cnt   <= '0;
      frame_err_cnt <= '0;
      last_err_mask <= '0;
      overflow      <= 1'b0;
      orphan        <= 1'b0;
    end else begin
      if (tx_valid && full)  overflow <= 1'b1;
      if (rx_valid && empty) orphan   <= 1'b1;
      if (pop) begin
        if (frame_cnt != CNT_MAX) frame_cnt <= frame_cnt + CNT_W'(1);
        bit_err_cnt <= bit_sum[CNT_W] ? CNT_MAX : bit_sum[CNT_W-1:0];
        if (m != '0) begin
          if (frame_err_cnt != CNT_MAX) frame_err_cnt <= frame_err_cnt + CNT_W'(1);
          last_err_mask <= m;
        end
      end
    end
  end

`ifdef BER_MONITOR_BURST_EN
  logic [CNT_W-1:0] burst_inc;
  assign burst_inc = (burst_cur == CNT_MAX) ? CNT_MAX : burst_cur + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      burst_cur <= '0;
      burst_max <= '0;
    end else if (pop) begin
      if (m != '0) begin
        burst_cur <= burst_inc;
        if (burst_inc > burst_max) burst_max <= burst_inc;
      end else begin
        burst_cur <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ber_monitor.sv
// Scoreboard bench for ber_monitor: a queue-based reference model predicts every
// post-edge output snapshot; a separate monitor pops and compares each cycle.
module tb_ber_monitor;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int MAXC   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, tx_valid, tx_ready, rx_valid, clear, overflow, orphan;
  logic [DATA_W-1:0] tx_data, rx_data, last_err_mask;
  logic [CNT_W-1:0]  frame_cnt, bit_err_cnt, frame_err_cnt;
  logic [LVL_W-1:0]  fifo_level;
`ifdef BER_MONITOR_BURST_EN
  logic [CNT_W-1:0]  burst_cur, burst_max;
`endif

  always #5 clk = ~clk;

  ber_monitor #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .clear         (clear),
    .frame_cnt     (frame_cnt),
    .bit_err_cnt   (bit_err_cnt),
    .frame_err_cnt (frame_err_cnt),
    .last_err_mask (last_err_mask),
    .overflow      (overflow),
    .orphan        (orphan),
`ifdef BER_MONITOR_BURST_EN
    .burst_cur     (burst_cur),
    .burst_max     (burst_max),
`endif
    .fifo_level    (fifo_level)
  );

  typedef struct {
    int          fc, bc, ec, bcur, bmax, lvl;
    logic [15:0] lm;
    bit          ov, orp, rdy;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mq[$];
  int          m_fc, m_bc, m_ec, m_bcur, m_bmax;
  logic [15:0] m_lm;
  bit          m_ov, m_orp;
  int          n_vec = 0;
  int          n_miss = 0;

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_zero_stats();
    m_fc = 0; m_bc = 0; m_ec = 0; m_lm = '0; m_ov = 0; m_orp = 0; m_bcur = 0; m_bmax = 0;
  endtask

  task automatic step(input bit r, input bit tv, input logic [15:0] td,
                      input bit rv, input logic [15:0] rd, input bit cl);
    int          lvl;
    bit          pop_ok, push_ok;
    logic [15:0] mm;
    exp_t        e;
    @(negedge clk);
    rst = r; tx_valid = tv; tx_data = td; rx_valid = rv; rx_data = rd; clear = cl;
    if (r) begin
      mq.delete();
      model_zero_stats();
    end else begin
      lvl     = mq.size();
      pop_ok  = rv && (lvl != 0);
      push_ok = tv && (lvl != DEPTH);
      mm      = '0;
      if (pop_ok)  mm = mq.pop_front() ^ rd;
      if (push_ok) mq.push_back(td);
      if (cl) begin
        model_zero_stats();
      end else begin
        if (tv && !push_ok) m_ov = 1;
        if (rv && lvl == 0) m_orp = 1;
        if (pop_ok) begin
          m_fc = sat(m_fc + 1);
          m_bc = sat(m_bc + $countones(mm));
          if (mm != 0) begin
            m_ec   = sat(m_ec + 1);
            m_lm   = mm;
            m_bcur = sat(m_bcur + 1);
            if (m_bcur > m_bmax) m_bmax = m_bcur;
          end else begin
            m_bcur = 0;
          end
        end
      end
    end
    e.fc = m_fc; e.bc = m_bc; e.ec = m_ec; e.lm = m_lm; e.ov = m_ov; e.orp = m_orp;
    e.bcur = m_bcur; e.bmax = m_bmax; e.lvl = mq.size(); e.rdy = (mq.size() != DEPTH);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    if (act != req) begin
      n_miss++;
      $display("FAIL %s at vector %0d: got %0h, expected %0h", name, n_vec, act, req);
    end
  endtask

  // Monitor: every edge produces one snapshot to check.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        chk("frame_cnt",     int'(frame_cnt),     e.fc);
        chk("bit_err_cnt",   int'(bit_err_cnt),   e.bc);
        chk("frame_err_cnt", int'(frame_err_cnt), e.ec);
        chk("last_err_mask", int'(last_err_mask), int'(e.lm));
        chk("overflow",      int'(overflow),      int'(e.ov));
        chk("orphan",        int'(orphan),        int'(e.orp));
        chk("fifo_level",    int'(fifo_level),    e.lvl);
        chk("tx_ready",      int'(tx_ready),      int'(e.rdy));
`ifdef BER_MONITOR_BURST_EN
        chk("burst_cur",     int'(burst_cur),     e.bcur);
        chk("burst_max",     int'(burst_max),     e.bmax);
`endif
      end
    end
  end

  task automatic do_reset();
    step(1, 0, '0, 0, '0, 0);
    step(0, 0, '0, 0, '0, 0);
  endtask

  task automatic rand_phase(input int cycles, input int clr_pct);
    logic [15:0] rd, flip;
    for (int i = 0; i < cycles; i++) begin
      flip = ($urandom_range(1, 0) == 1) ? 16'($urandom) : 16'h0;
      rd   = (mq.size() != 0) ? (mq[0] ^ flip) : 16'($urandom);
      step(($urandom_range(399, 0) == 0), ($urandom_range(99, 0) < 55), 16'($urandom),
           ($urandom_range(99, 0) < 50), rd, ($urandom_range(999, 0) < clr_pct));
    end
  endtask

  initial begin
    rst = 1'b1; tx_valid = 0; tx_data = '0; rx_valid = 0; rx_data = '0; clear = 0;
    do_reset();

    // Matching frame, then two errored frames (1 bit + 16 bits).
    step(0, 1, 16'h147C, 0, '0, 0);
    step(0, 0, '0, 1, 16'h147C, 0);
    do_reset();
    step(0, 1, 16'h147C, 0, '0, 0);
    step(0, 0, '0, 1, 16'h147D, 0);
    step(0, 1, 16'hFFFF, 0, '0, 0);
    step(0, 0, '0, 1, 16'h0000, 0);

    // Fill, overflow, simultaneous push+pop at full, then drain.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(0, 1, 16'(16'hA000 + i), 0, '0, 0);
    step(0, 1, 16'hDEAD, 0, '0, 0);
    step(0, 1, 16'hBEEF, 1, 16'hA000, 0);
    step(0, 1, 16'h1234, 0, '0, 0);
    for (int i = 1; i < DEPTH; i++) step(0, 0, '0, 1, 16'(16'hA000 + i), 0);
    step(0, 0, '0, 1, 16'h1234, 0);
    step(0, 1, 16'h5555, 1, 16'h5555, 0);

    // Orphan with same-cycle push into an empty FIFO.
    do_reset();
    step(0, 1, 16'h0F0F, 1, 16'h0F0F, 0);
    step(0, 0, '0, 1, 16'h0F0E, 0);

    // Clear with an errored rx at level 2.
    do_reset();
    step(0, 1, 16'h1111, 0, '0, 0);
    step(0, 0, '0, 1, 16'h0000, 0);
    step(0, 1, 16'h2222, 0, '0, 0);
    step(0, 1, 16'h3333, 0, '0, 0);
    step(0, 0, '0, 1, 16'h2223, 1);
    step(0, 0, '0, 1, 16'h3333, 0);

    // Reset mid-flight discards references.
    step(0, 1, 16'h4444, 0, '0, 0);
    step(0, 1, 16'h4545, 0, '0, 0);
    step(1, 0, '0, 0, '0, 0);
    step(0, 0, '0, 1, 16'h4444, 0);

    // Burst pattern err,err,ok,err,err,err,ok.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 16'(16'h7000 + i), 0, '0, 0);
      step(0, 0, '0, 1, 16'(16'h7000 + i) ^ ((i == 2 || i == 6) ? 16'h0 : 16'h0101), 0);
    end

    rand_phase(600, 8);
    rand_phase(1500, 0);

    step(0, 0, '0, 0, '0, 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d snapshots unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
